// File: rtl/keccak_pkg.sv
// Shared types and widths for the keccak core arbiter.
package keccak_pkg;

    localparam int DIGEST_W = 512;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        WAIT   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/keccak_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the other requester on every grant.
module keccak_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt_valid_o = en_i && (req_i != 2'b00);
        gnt_id_o    = (req_i == 2'b11) ? rr_ptr_q : req_i[1];
        rr_ptr_d    = gnt_valid_o ? ~gnt_id_o : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core between two message requesters, one whole message per grant,
// clearing the core before each message and returning the tagged digest.
module keccak_arbiter
    import keccak_pkg::*;
#(
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   r0_in,
    input  logic                r0_in_ready,
    input  logic                r0_is_last,
    input  logic [1:0]          r0_byte_num,
    output logic                r0_full,
    input  logic [WORD_W-1:0]   r1_in,
    input  logic                r1_in_ready,
    input  logic                r1_is_last,
    input  logic [1:0]          r1_byte_num,
    output logic                r1_full,
    output logic                core_reset,
    output logic [WORD_W-1:0]   core_in,
    output logic                core_in_ready,
    output logic                core_is_last,
    output logic [1:0]          core_byte_num,
    input  logic                core_buffer_full,
    input  logic [DIGEST_W-1:0] core_out,
    input  logic                core_out_ready,
    output logic [DIGEST_W-1:0] out,
    output logic                out_valid,
    output logic                out_id,
    output logic                timeout_err,
    output logic [1:0]          dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [3:0]          clr_cnt_q, clr_cnt_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [DIGEST_W-1:0] out_q, out_d;
    logic                out_id_q, out_id_d;
    logic                out_valid_q, out_valid_d;
    logic                timeout_err_q, timeout_err_d;

    logic                gnt_valid, gnt_id;
    logic [WORD_W-1:0]   sel_in;
    logic                sel_ready, sel_last, accept;
    logic [1:0]          sel_bn;

    keccak_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (reset),
        .en_i        (state_q == IDLE),
        .req_i       ({r1_in_ready, r0_in_ready}),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // Handshake: a word moves (requester -> core) on a clock edge where in_ready==1
    // and full==0; full is core_buffer_full for the granted requester, else 1.
    assign sel_in    = gnt_q ? r1_in       : r0_in;
    assign sel_ready = gnt_q ? r1_in_ready : r0_in_ready;
    assign sel_last  = gnt_q ? r1_is_last  : r0_is_last;
    assign sel_bn    = gnt_q ? r1_byte_num : r0_byte_num;
    assign accept    = sel_ready && !core_buffer_full;

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        clr_cnt_d     = clr_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        out_d         = out_q;
        out_id_d      = out_id_q;
        out_valid_d   = 1'b0;
        timeout_err_d = 1'b0;
        core_reset    = 1'b1;
        core_in       = sel_in;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = sel_bn;
        r0_full       = 1'b1;
        r1_full       = 1'b1;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    gnt_d     = gnt_id;
                    clr_cnt_d = 4'd0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == 4'(CLR_CYCLES - 1)) begin
                    state_d = STREAM;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            STREAM: begin
                core_reset    = 1'b0;
                core_in_ready = sel_ready;
                core_is_last  = sel_ready && sel_last;
                r0_full       = gnt_q ? 1'b1 : core_buffer_full;
                r1_full       = gnt_q ? core_buffer_full : 1'b1;
                if (accept && sel_last) begin
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                core_reset = 1'b0;
                // A digest arriving on the last allowed cycle still wins over the abort.
                if (core_out_ready) begin
                    out_d       = core_out;
                    out_id_d    = gnt_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            clr_cnt_q     <= 4'd0;
            wait_cnt_q    <= '0;
            out_q         <= '0;
            out_id_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            clr_cnt_q     <= clr_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            out_q         <= out_d;
            out_id_q      <= out_id_d;
            out_valid_q   <= out_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign out         = out_q;
    assign out_id      = out_id_q;
    assign out_valid   = out_valid_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter: vector table of single messages plus
// hand-written arbitration, back-to-back and mid-message reset sequences.
module tb_keccak_arbiter;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  r0_in = '0, r1_in = '0;
    logic         r0_in_ready = 1'b0, r1_in_ready = 1'b0;
    logic         r0_is_last = 1'b0, r1_is_last = 1'b0;
    logic [1:0]   r0_byte_num = '0, r1_byte_num = '0;
    logic         r0_full, r1_full;
    logic         core_reset, core_in_ready, core_is_last;
    logic [31:0]  core_in;
    logic [1:0]   core_byte_num;
    logic         core_buffer_full = 1'b0;
    logic [511:0] core_out = '0;
    logic         core_out_ready = 1'b0;
    logic [511:0] out;
    logic         out_valid, out_id, timeout_err;
    logic [1:0]   dbg_state;

    keccak_arbiter #(.CLR_CYCLES(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .r0_in(r0_in), .r0_in_ready(r0_in_ready), .r0_is_last(r0_is_last),
        .r0_byte_num(r0_byte_num), .r0_full(r0_full),
        .r1_in(r1_in), .r1_in_ready(r1_in_ready), .r1_is_last(r1_is_last),
        .r1_byte_num(r1_byte_num), .r1_full(r1_full),
        .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready),
        .core_is_last(core_is_last), .core_byte_num(core_byte_num),
        .core_buffer_full(core_buffer_full), .core_out(core_out),
        .core_out_ready(core_out_ready),
        .out(out), .out_valid(out_valid), .out_id(out_id),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / checks ----------------
    int total = 0;
    int bad = 0;

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_digest(input logic [31:0] sum, input logic [31:0] x,
                                               input logic [31:0] cnt, input logic [1:0] bn);
        return {{12{sum ^ 32'hA5A5_0000}}, 30'd0, bn, cnt, x, sum};
    endfunction

    function automatic logic [511:0] exp_digest(input int n, input logic [1:0] bn, input logic [31:0] base);
        logic [31:0] s, x, w;
        s = '0;
        x = '0;
        for (int i = 0; i < n; i++) begin
            w = base + 32'(i);
            s = s + w;
            x = x ^ w;
        end
        return mk_digest(s, x, 32'(n), bn);
    endfunction

    // ---------------- core model ----------------
    logic [31:0]  acc_sum = '0, acc_x = '0, acc_cnt = '0;
    logic [511:0] pend_digest = '0;
    int           pend_cnt = -1;
    int           resp_delay = 1;
    int           words_seen = 0;

    always @(negedge clk) begin
        core_out_ready = 1'b0;
        if (core_reset) begin
            acc_sum = '0; acc_x = '0; acc_cnt = '0; pend_cnt = -1;
        end else begin
            if (pend_cnt == 0) begin
                core_out_ready = 1'b1;
                core_out = pend_digest;
                pend_cnt = -1;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
            if (core_in_ready && !core_buffer_full) begin
                words_seen++;
                acc_sum = acc_sum + core_in;
                acc_x   = acc_x ^ core_in;
                acc_cnt = acc_cnt + 32'd1;
                if (core_is_last) begin
                    pend_digest = mk_digest(acc_sum, acc_x, acc_cnt, core_byte_num);
                    acc_sum = '0; acc_x = '0; acc_cnt = '0;
                    if (resp_delay >= 0) pend_cnt = resp_delay;
                end
            end
        end
    end

    logic bf_mode = 1'b0;
    always @(posedge clk) begin
        #2;
        if (bf_mode) core_buffer_full = ~core_buffer_full;
        else core_buffer_full = 1'b0;
    end

    // ---------------- scoreboard / monitors ----------------
    logic [512:0] exp_q[$];
    logic [512:0] e;
    int outs = 0, tmos = 0, viol = 0, cur_id = -1;
    int wait_run = 0, last_wait_run = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            outs++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_valid_unexpected: got pulse id=%0d want none", out_id);
            end else begin
                e = exp_q.pop_front();
                check_int("out_id", int'(out_id), int'(e[512]));
                check_vec("out", out, e[511:0]);
            end
        end
        if (timeout_err) tmos++;
        if (dbg_state == 2'd3) wait_run++;
        else if (wait_run != 0) begin
            last_wait_run = wait_run;
            wait_run = 0;
        end
        if (dbg_state != 2'd2) begin
            if (!(r0_full && r1_full) || core_in_ready || (core_reset != (dbg_state < 2'd2))) viol++;
        end else begin
            if (core_reset || (!r0_full && !r1_full)) viol++;
            if (!core_buffer_full && r0_full && r1_full) viol++;
            if (core_buffer_full && !(r0_full && r1_full)) viol++;
            if (cur_id == 0 && (!r1_full || r0_full != core_buffer_full || core_in_ready != r0_in_ready)) viol++;
            if (cur_id == 1 && (!r0_full || r1_full != core_buffer_full || core_in_ready != r1_in_ready)) viol++;
        end
        if (!core_in_ready && core_is_last) viol++;
    end

    // ---------------- drivers ----------------
    logic abort = 1'b0;

    task automatic drive(input int id, input logic v, input logic [31:0] w, input logic l, input logic [1:0] bn);
        if (id == 0) begin
            r0_in_ready = v; r0_in = w; r0_is_last = l; r0_byte_num = bn;
        end else begin
            r1_in_ready = v; r1_in = w; r1_is_last = l; r1_byte_num = bn;
        end
    endtask

    task automatic send_msg(input int id, input int n, input logic [1:0] bn, input logic [31:0] base);
        int  i = 0;
        int  guard = 0;
        logic took;
        while (i < n && guard < 500 && !abort) begin
            drive(id, 1'b1, base + 32'(i), (i == n - 1), bn);
            @(negedge clk);
            took = (id == 0) ? !r0_full : !r1_full;
            @(posedge clk);
            #1;
            if (took) i++;
            guard++;
        end
        drive(id, 1'b0, 32'h0, 1'b0, 2'd0);
        if (guard >= 500) begin
            total++;
            bad++;
            $display("FAIL send_stall: req %0d sent %0d of %0d words", id, i, n);
        end
    endtask

    task automatic check_startup(input string tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_int({tag, "_state"}, int'(dbg_state), (k == 0) ? 0 : ((k == 3) ? 2 : 1));
            check_int({tag, "_core_reset"}, int'(core_reset), (k == 3) ? 0 : 1);
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (dbg_state != 2'd0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: state=%0d want 0", dbg_state);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          id;
        int          n;
        logic [1:0]  bn;
        logic [31:0] base;
        int          delay;
        logic        bf;
        int          exp_words;
        int          exp_outs;
        int          exp_tmo;
        int          exp_wait;
    } vec_t;

    vec_t         tbl[5];
    int           w0, o0, t0, v0;
    logic [511:0] last_dig;
    logic         last_id;

    initial begin
        tbl[0] = '{0, 3, 2'd2, 32'h1000_0000, 2,  1'b0, 3, 1, 0, 3};
        tbl[1] = '{1, 1, 2'd0, 32'hDEAD_BEEF, 0,  1'b0, 1, 1, 0, 1};
        tbl[2] = '{0, 5, 2'd3, 32'hFFFF_FFFE, 7,  1'b1, 5, 1, 0, 8};
        tbl[3] = '{1, 4, 2'd1, 32'h0123_4567, 3,  1'b1, 4, 1, 0, 4};
        tbl[4] = '{0, 2, 2'd1, 32'h7777_0000, -1, 1'b0, 2, 0, 1, TMO};

        // reset values
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_int("rst_state", int'(dbg_state), 0);
        check_int("rst_core_reset", int'(core_reset), 1);
        check_int("rst_core_in_ready", int'(core_in_ready), 0);
        check_int("rst_r0_full", int'(r0_full), 1);
        check_int("rst_r1_full", int'(r1_full), 1);
        check_vec("rst_out", out, 512'd0);
        check_int("rst_out_id", int'(out_id), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_timeout_err", int'(timeout_err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // both pending in the first IDLE after reset: r0 first, then r1
        o0 = outs;
        v0 = viol;
        resp_delay = 1;
        exp_q.push_back({1'b0, exp_digest(3, 2'd2, 32'h1000_0000)});
        exp_q.push_back({1'b1, exp_digest(2, 2'd1, 32'h2000_0000)});
        fork
            send_msg(0, 3, 2'd2, 32'h1000_0000);
            send_msg(1, 2, 2'd1, 32'h2000_0000);
            check_startup("first");
        join
        wait_idle();
        check_int("pair_outs", outs - o0, 2);
        check_int("pair_viol", viol - v0, 0);

        // four back-to-back messages alternate 0,1,0,1
        o0 = outs;
        w0 = words_seen;
        exp_q.push_back({1'b0, exp_digest(2, 2'd3, 32'h3000_0000)});
        exp_q.push_back({1'b1, exp_digest(4, 2'd2, 32'h4000_0000)});
        exp_q.push_back({1'b0, exp_digest(3, 2'd0, 32'h3100_0000)});
        exp_q.push_back({1'b1, exp_digest(1, 2'd3, 32'h4100_0000)});
        fork
            begin
                send_msg(0, 2, 2'd3, 32'h3000_0000);
                send_msg(0, 3, 2'd0, 32'h3100_0000);
            end
            begin
                send_msg(1, 4, 2'd2, 32'h4000_0000);
                send_msg(1, 1, 2'd3, 32'h4100_0000);
            end
        join
        wait_idle();
        check_int("alt_outs", outs - o0, 4);
        check_int("alt_words", words_seen - w0, 10);

        // single-message vector table
        for (int k = 0; k < 5; k++) begin
            w0 = words_seen;
            o0 = outs;
            t0 = tmos;
            v0 = viol;
            cur_id = tbl[k].id;
            resp_delay = tbl[k].delay;
            bf_mode = tbl[k].bf;
            if (tbl[k].exp_outs != 0) begin
                last_dig = exp_digest(tbl[k].n, tbl[k].bn, tbl[k].base);
                last_id = 1'(tbl[k].id);
                exp_q.push_back({last_id, last_dig});
            end
            send_msg(tbl[k].id, tbl[k].n, tbl[k].bn, tbl[k].base);
            wait_idle();
            bf_mode = 1'b0;
            cur_id = -1;
            check_int($sformatf("v%0d_words", k), words_seen - w0, tbl[k].exp_words);
            check_int($sformatf("v%0d_outs", k), outs - o0, tbl[k].exp_outs);
            check_int($sformatf("v%0d_timeouts", k), tmos - t0, tbl[k].exp_tmo);
            check_int($sformatf("v%0d_wait_cycles", k), last_wait_run, tbl[k].exp_wait);
            check_int($sformatf("v%0d_state", k), int'(dbg_state), 0);
            check_int($sformatf("v%0d_viol", k), viol - v0, 0);
            if (tbl[k].exp_tmo != 0) begin
                check_vec($sformatf("v%0d_out_hold", k), out, last_dig);
                check_int($sformatf("v%0d_out_id_hold", k), int'(out_id), int'(last_id));
            end
        end

        // reset pulled low mid-STREAM
        o0 = outs;
        w0 = words_seen;
        resp_delay = 1;
        cur_id = 0;
        fork
            send_msg(0, 6, 2'd3, 32'h5000_0000);
            begin
                int g;
                g = 0;
                while (words_seen < w0 + 2 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                check_int("mid_reached_stream", int'(dbg_state), 2);
                @(posedge clk);
                #3;
                reset = 1'b0;
                abort = 1'b1;
                #1;
                check_int("mid_state", int'(dbg_state), 0);
                check_int("mid_core_reset", int'(core_reset), 1);
                check_int("mid_core_in_ready", int'(core_in_ready), 0);
                check_int("mid_r0_full", int'(r0_full), 1);
                check_int("mid_r1_full", int'(r1_full), 1);
                check_int("mid_out_valid", int'(out_valid), 0);
                check_vec("mid_out", out, 512'd0);
                @(posedge clk);
                #3;
                reset = 1'b1;
            end
        join
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check_int("mid_no_out", outs - o0, 0);
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, exp_digest(2, 2'd1, 32'h6000_0000)});
        fork
            send_msg(0, 2, 2'd1, 32'h6000_0000);
            check_startup("after_rst");
        join
        wait_idle();
        cur_id = -1;
        check_int("after_rst_outs", outs - o0, 1);

        check_int("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
